full_adder: RTL and testbench



---
 rtl/full_adder.sv | 61 ++++++
 tb/tb_full_adder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// full_adder: ripple-carry adder cell (WIDTH=1 is the classic full adder) with
// a combinational sum/carry path and a one-cycle registered copy plus valid.
// Revision: 1.0
// ============================================================================
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // Carry chain built in one process so each stage reads the previous one.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]     = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end
  end

  // Carry into the MSB vs. carry out of it; for WIDTH=1 this is cin ^ cout.
  assign w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];
  assign sum   = w_sum;
  assign cout  = w_carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum_q     <= w_sum;
      cout_q    <= w_carry[WIDTH];
      ovf_q     <= w_ovf;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// Testbench for full_adder: WIDTH=1 truth table, WIDTH=8 directed sequences,
// WIDTH=16 randomized regression against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic a1, b1, cin1, iv1;
  logic s1, co1, sq1, coq1, ovq1, ov1;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, sq8;
  logic cin8, iv8, co8, coq8, ovq8, ov8;
  // WIDTH=16 instance
  logic [15:0] a16, b16, s16, sq16;
  logic cin16, iv16, co16, coq16, ovq16, ov16;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(s1), .cout(co1), .sum_q(sq1), .cout_q(coq1), .ovf_q(ovq1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(s8), .cout(co8), .sum_q(sq8), .cout_q(coq8), .ovf_q(ovq8), .out_valid(ov8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .in_valid(iv16),
    .sum(s16), .cout(co16), .sum_q(sq16), .cout_q(coq16), .ovf_q(ovq16), .out_valid(ov16)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a, b, cin;
    logic sum, cout;
  } tt_t;
  tt_t tt[8];

  // Registered-path expectation for the 16-bit regression.
  logic [15:0] m_sum;
  logic        m_cout, m_ovf, m_valid;

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;
    a16 = 0; b16 = 0; cin16 = 0; iv16 = 0;
    tick();
    tick();

    check("reset_w8", {ov8, ovq8, coq8, sq8}, 64'h0);
    check("reset_w16", {ov16, ovq16, coq16, sq16}, 64'h0);
    check("reset_w1", {ov1, ovq1, coq1, sq1}, 64'h0);

    // Combinational outputs do not depend on reset.
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b1;
    #1;
    check("comb_in_reset_w8", {co8, s8}, 64'h011);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = tt[i].a; b1 = tt[i].b; cin1 = tt[i].cin;
      #10;
      check($sformatf("truth_%0d%0d%0d", tt[i].a, tt[i].b, tt[i].cin),
            {co1, s1}, {tt[i].cout, tt[i].sum});
    end

    // 0xFF + 0x01: wraps with carry, no signed overflow.
    tick();
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; iv8 = 1'b1;
    #1;
    check("ff01_comb", {co8, s8}, 64'h100);
    tick();
    check("ff01_reg", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b0, 1'b1, 8'h00});
    iv8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    tick();
    check("ff01_hold", {ov8, ovq8, coq8, sq8}, {1'b0, 1'b0, 1'b1, 8'h00});

    a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; iv8 = 1'b1;
    tick();
    check("ovf_7f_00_1", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b1, 1'b0, 8'h80});
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    tick();
    check("ovf_80_80_0", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b1, 1'b1, 8'h00});

    // Back-to-back stream.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    tick();
    check("b2b_0", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b0, 1'b0, 8'h03});
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b1;
    tick();
    check("b2b_1", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b0, 1'b0, 8'h08});
    a8 = 8'hFE; b8 = 8'h01; cin8 = 1'b1;
    tick();
    check("b2b_2", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b0, 1'b1, 8'h00});
    iv8 = 1'b0;
    tick();
    check("b2b_end", {ov8, ovq8, coq8, sq8}, {1'b0, 1'b0, 1'b1, 8'h00});

    // Reset mid-stream wins over in_valid on the same edge.
    a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; iv8 = 1'b1;
    tick();
    check("pre_reset", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b1, 1'b0, 8'h80});
    rst = 1'b1; a8 = 8'h05; b8 = 8'h05; cin8 = 1'b0;
    #1;
    check("reset_comb_0a", {co8, s8}, 64'h00A);
    tick();
    check("reset_mid", {ov8, ovq8, coq8, sq8}, 64'h0);
    rst = 1'b0;
    tick();
    check("first_after_reset", {ov8, ovq8, coq8, sq8}, {1'b1, 1'b0, 1'b0, 8'h0A});
    iv8 = 1'b0;

    // Randomized 16-bit regression.
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      int sa, sb, ss;
      logic [16:0] usum;
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); iv16 = ($urandom_range(0, 3) != 0);
      usum = {1'b0, a16} + {1'b0, b16} + {16'h0, cin16};
      #1;
      check($sformatf("rnd_comb_%0d", n), {co16, s16}, usum);
      sa = int'($signed(a16)); sb = int'($signed(b16));
      ss = sa + sb + int'(cin16);
      if (iv16) begin
        m_sum = usum[15:0]; m_cout = usum[16];
        m_ovf = (ss > 32767) || (ss < -32768);
      end
      m_valid = iv16;
      tick();
      check($sformatf("rnd_reg_%0d", n), {ov16, ovq16, coq16, sq16},
            {m_valid, m_ovf, m_cout, m_sum});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
